// File: rtl/addru_pkg.sv
// Shared sizing helpers for the segmented pipelined adder.
package addru_pkg;

   // Sanity limit on the width of one segment adder.
   localparam int unsigned MAX_SEG = 64;

   // Number of pipeline stages: ceil(width / seg).
   function automatic int unsigned stages_f(input int unsigned width, input int unsigned seg);
      return (width + seg - 1) / seg;
   endfunction

   // Width of segment k; only the last segment may be narrower than seg.
   function automatic int unsigned seg_w_f(input int unsigned width, input int unsigned seg,
                                           input int unsigned k);
      if (k + 1 < stages_f(width, seg)) begin
         return seg;
      end
      return width - seg * (stages_f(width, seg) - 1);
   endfunction

endpackage

// File: rtl/addru_seg.sv
// Combinational SEG-bit ripple-carry adder used for one pipeline segment.
module addru_seg #(
   parameter int unsigned SEG = 4
) (
   input  logic [SEG-1:0] x,
   input  logic [SEG-1:0] y,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co
);

   logic [SEG:0] c;

   // Bit-serial ripple: each carry feeds the next bit position.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int unsigned i = 0; i < SEG; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co = c[SEG];

endmodule

// File: rtl/addru_pipe_seg.sv
// Pipelined unsigned adder: WIDTH-bit operands, carry chain cut into SEG-bit
// segments with one register stage per segment and valid/ready on both sides.
// Optional macro ADDR_DMR_EN duplicates every segment adder and raises a sticky
// err flag when the duplicate disagrees with the primary on a stage load.
module addru_pipe_seg
   import addru_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             err
);

   localparam int unsigned STAGES = stages_f(WIDTH, SEG);

   if (WIDTH < 1 || SEG < 1 || SEG > WIDTH || SEG > MAX_SEG) begin : g_bad_cfg
      $error("addru_pipe_seg: unsupported WIDTH/SEG combination");
   end

   // Per-stage state: valid, carry out of the segment, partial sum (low bits),
   // and the still-unprocessed operand bits shifted down to bit 0.
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] c_q;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  p_q [STAGES];

   // Values each stage would capture on its next advance.
   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] c_nx;
   logic [WIDTH-1:0]  a_nx [STAGES];
   logic [WIDTH-1:0]  b_nx [STAGES];
   logic [WIDTH-1:0]  p_nx [STAGES];

   // adv[k]: stage k may load this cycle; adv[STAGES] is the consumer.
   logic [STAGES:0]   adv;

`ifdef ADDR_DMR_EN
   logic [STAGES-1:0] mis;
`endif

   // Ready ripples backwards: a stage moves if it is empty or the next one moves.
   always_comb begin
      adv         = '0;
      adv[STAGES] = out_ready;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         adv[k] = !v_q[k] || adv[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned LO = SEG * k;
      localparam int unsigned LW = seg_w_f(WIDTH, SEG, k);

      logic             c_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] p_in;
      logic [LW-1:0]    seg_s;
      logic             seg_co;

      if (k == 0) begin : g_head
         assign v_in[k] = in_valid;
         assign c_in    = 1'b0;
         assign a_in    = a;
         assign b_in    = b;
         assign p_in    = '0;
      end else begin : g_tail
         assign v_in[k] = v_q[k-1];
         assign c_in    = c_q[k-1];
         assign a_in    = a_q[k-1];
         assign b_in    = b_q[k-1];
         assign p_in    = p_q[k-1];
      end

      addru_seg #(
         .SEG (LW)
      ) u_prim (
         .x  (a_in[LW-1:0]),
         .y  (b_in[LW-1:0]),
         .ci (c_in),
         .s  (seg_s),
         .co (seg_co)
      );

      assign c_nx[k] = seg_co;
      assign a_nx[k] = a_in >> LW;
      assign b_nx[k] = b_in >> LW;
      assign p_nx[k] = p_in | (WIDTH'(seg_s) << LO);

`ifdef ADDR_DMR_EN
      logic [LW-1:0] dup_s;
      logic          dup_co;

      // Shadow copy; attributes stop synthesis from merging it with u_prim.
      (* dont_touch = "true", keep = "true" *)
      addru_seg #(
         .SEG (LW)
      ) u_dup (
         .x  (a_in[LW-1:0]),
         .y  (b_in[LW-1:0]),
         .ci (c_in),
         .s  (dup_s),
         .co (dup_co)
      );

      assign mis[k] = v_in[k] && ({dup_co, dup_s} != {seg_co, seg_s});
`endif
   end

   // Stage registers: valid follows every advance, data only loads with valid input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         c_q <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            p_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               v_q[k] <= v_in[k];
               if (v_in[k]) begin
                  c_q[k] <= c_nx[k];
                  a_q[k] <= a_nx[k];
                  b_q[k] <= b_nx[k];
                  p_q[k] <= p_nx[k];
               end
            end
         end
      end
   end

`ifdef ADDR_DMR_EN
   logic err_q;

   // Sticky fault flag: set when any stage loads a result its duplicate disputes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (|(mis & adv[STAGES-1:0])) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign in_ready  = adv[0];
   assign out_valid = v_q[STAGES-1];
   assign sum       = {c_q[STAGES-1], p_q[STAGES-1]};

endmodule

// File: tb/tb_addru_pipe_seg.sv
// Bench for addru_pipe_seg: an 8/4 instance and a 7/3 instance share one
// stimulus stream and are checked against an in-order queue model.
module tb_addru_pipe_seg;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_ready;

   logic       in_ready0, out_valid0, err0;
   logic [8:0] sum0;
   logic       in_ready1, out_valid1, err1;
   logic [7:0] sum1;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Model state per instance: FIFO of expected sums and their accept edge.
   int          q_sum [2][8];
   int          q_acc [2][8];
   int          head [2];
   int          cnt [2];
   int          last_stall [2];
   logic        held_v [2];
   logic [8:0]  held_s [2];
   logic [1:0]  exp_err;
   int          stg [2];

   logic [7:0] t2a [4];
   logic [7:0] t2b [4];
   logic [8:0] t2s [4];

   addru_pipe_seg #(
      .WIDTH (8),
      .SEG   (4)
   ) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .a         (a),
      .b         (b),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .sum       (sum0),
      .err       (err0)
   );

   addru_pipe_seg #(
      .WIDTH (7),
      .SEG   (3)
   ) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .a         (a[6:0]),
      .b         (b[6:0]),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .sum       (sum1),
      .err       (err1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flush();
      for (int d = 0; d < 2; d++) begin
         head[d]       = 0;
         cnt[d]        = 0;
         held_v[d]     = 1'b0;
         last_stall[d] = -1;
      end
      exp_err = 2'b00;
   endtask

   // Compare one instance at the negedge, then apply the transfers of the coming edge.
   task automatic check_dut(input int d, input logic irdy, input logic ov, input logic [8:0] s,
                            input logic e);
      int lat;
      int expv;
      chk($sformatf("dut%0d_in_ready", d), irdy, (out_ready || cnt[d] < stg[d]));
      chk($sformatf("dut%0d_err", d), e, exp_err[d]);
      if (cnt[d] == 0) chk($sformatf("dut%0d_idle_out_valid", d), ov, 0);
      if (held_v[d]) begin
         chk($sformatf("dut%0d_hold_valid", d), ov, 1);
         chk($sformatf("dut%0d_hold_sum", d), s, held_s[d]);
      end
      if (ov && cnt[d] > 0) begin
         chk($sformatf("dut%0d_sum", d), s, q_sum[d][head[d]]);
         lat = cyc - q_acc[d][head[d]];
         if (last_stall[d] <= q_acc[d][head[d]])
            chk($sformatf("dut%0d_latency", d), lat, stg[d] - 1);
         else
            chk($sformatf("dut%0d_latency_min", d), (lat >= stg[d] - 1), 1);
      end
      held_v[d] = 1'b0;
      if (ov && out_ready && cnt[d] > 0) begin
         head[d] = (head[d] + 1) % 8;
         cnt[d]--;
      end else if (ov && !out_ready) begin
         held_v[d]     = 1'b1;
         held_s[d]     = s;
         last_stall[d] = cyc + 1;
      end
      if (in_valid && irdy && cnt[d] < 8) begin
         expv = (d == 0) ? (int'(a) + int'(b)) : (int'(a) % 128 + int'(b) % 128);
         q_sum[d][(head[d] + cnt[d]) % 8] = expv;
         q_acc[d][(head[d] + cnt[d]) % 8] = cyc + 1;
         cnt[d]++;
      end
   endtask

   // Single compare process for both instances.
   initial begin
      stg[0] = 2;
      stg[1] = 3;
      flush();
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_out_valid0", out_valid0, 0);
            chk("rst_sum0", sum0, 0);
            chk("rst_out_valid1", out_valid1, 0);
            chk("rst_sum1", sum1, 0);
            chk("rst_err0", err0, 0);
            flush();
         end else begin
            check_dut(0, in_ready0, out_valid0, sum0, err0);
            check_dut(1, in_ready1, out_valid1, {1'b0, sum1}, err1);
         end
      end
   end

   initial begin
      t2a = '{8'h12, 8'h80, 8'h00, 8'hF0};
      t2b = '{8'h34, 8'h80, 8'h00, 8'h0F};
      t2s = '{9'h046, 9'h100, 9'h000, 9'h0FF};
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // 0xFF + 0x01 through the 2-stage instance.
      @(posedge clk); #1;
      in_valid = 1'b1; a = 8'hFF; b = 8'h01;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_not_early", out_valid0, 0);
      @(negedge clk);
      chk("t1_valid", out_valid0, 1);
      chk("t1_sum", sum0, 9'h100);
      @(negedge clk);
      chk("t1_w7_valid", out_valid1, 1);
      chk("t1_w7_sum", sum1, 8'h80);

      // Back-to-back stream.
      for (int j = 0; j < 6; j++) begin
         @(posedge clk); #1;
         if (j < 4) begin
            in_valid = 1'b1; a = t2a[j]; b = t2b[j];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (j < 4) chk("t2_in_ready", in_ready0, 1);
         if (j >= 2) begin
            chk("t2_valid", out_valid0, 1);
            chk("t2_sum", sum0, t2s[j-2]);
         end
      end

      // 0x7F + 0x7F: 3-stage instance has latency 3, last segment 1 bit.
      @(posedge clk); #1;
      in_valid = 1'b1; a = 8'h7F; b = 8'h7F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_w8_sum", sum0, 9'h0FE);
      chk("t5_w7_not_early", out_valid1, 0);
      @(negedge clk);
      chk("t5_w7_valid", out_valid1, 1);
      chk("t5_w7_sum", sum1, 8'hFE);
      repeat (3) @(posedge clk);

      // Backpressure with a continuous stream.
      #1 out_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      end
      @(negedge clk);
      chk("t3_full_in_ready0", in_ready0, 0);
      chk("t3_full_in_ready1", in_ready1, 0);
      chk("t3_full_out_valid0", out_valid0, 1);
      for (int j = 0; j < 6; j++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         in_valid  = (j < 4);
         a = 8'($urandom); b = 8'($urandom);
      end

      // Reset with results in flight.
      @(posedge clk); #1;
      in_valid = 1'b1; a = 8'h21; b = 8'h43;
      @(posedge clk); #1;
      a = 8'h55; b = 8'hAA;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("t4_out_valid0", out_valid0, 0);
      chk("t4_sum0", sum0, 0);
      chk("t4_out_valid1", out_valid1, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t4_release_in_ready0", in_ready0, 1);
      repeat (5) @(posedge clk);

      // Randomized traffic with occasional resets.
      for (int j = 0; j < 1500; j++) begin
         @(posedge clk); #1;
         rst       = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = (j % 200 < 100) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0);
         a = 8'($urandom);
         b = 8'($urandom);
      end
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (6) @(posedge clk);

`ifdef ADDR_DMR_EN
      // Corrupt the stage-1 duplicate carry for the cycle the operand advances into it.
      #1 in_valid = 1'b1; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      in_valid = 1'b0;
      force u_dut0.g_stage[1].dup_co = 1'b1;
      @(posedge clk); #1;
      release u_dut0.g_stage[1].dup_co;
      exp_err[0] = 1'b1;
      @(negedge clk);
      chk("t6_err_set", err0, 1);
      chk("t6_primary_sum", sum0, 9'h033);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t6_err_sticky", err0, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_err_cleared", err0, 0);
`endif

      // Drain: every accepted operand pair must have come out.
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("drain_dut0_empty", cnt[0], 0);
      chk("drain_dut1_empty", cnt[1], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
